// File: rtl/stopwatch_ctrl_if.sv
// Button/counter/display bundle between the stopwatch controller and its surroundings.
// The controller takes the master side; board buttons and the seconds counter take the slave side.
interface stopwatch_ctrl_if #(
    parameter int CW = 19
);
    logic          btn_ss;
    logic          btn_lr;
    logic [CW-1:0] sec_count;
    logic          cnt_inc;
    logic          cnt_clr;
    logic [CW-1:0] disp_value;
    logic [1:0]    state;
    logic          running;
    logic          ovf;

    modport master (
        input  btn_ss, btn_lr, sec_count,
        output cnt_inc, cnt_clr, disp_value, state, running, ovf
    );

    modport slave (
        output btn_ss, btn_lr, sec_count,
        input  cnt_inc, cnt_clr, disp_value, state, running, ovf
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button edge detect, run/lap/stop FSM, one-second prescaler,
// lap latch and display mux, with a sticky flag when the count reaches its terminal value.

// One button: 2-FF synchronizer plus a history flop, giving one pulse per rising edge.
module stopwatch_btn (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic [2:0] sync_pipe;  // [0]=s1, [1]=s2, [2]=s3

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[1:0], btn};
    end

    assign press = sync_pipe[1] & ~sync_pipe[2];
endmodule

module stopwatch_ctrl #(
    parameter int DIV       = 50_000_000,
    parameter int CW        = 19,
    parameter int MAX_COUNT = 359_999
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LAP  = 2'b10,
        STOP = 2'b11
    } state_t;

    localparam int            PW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_TOP   = CW'(MAX_COUNT);
    localparam int            NUM_BTN   = 2;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;
    logic               ss;
    logic               lr;

    assign raw = {bus.btn_lr, bus.btn_ss};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        stopwatch_btn u_btn (
            .clk   (clk),
            .reset (reset),
            .btn   (raw[i]),
            .press (press[i])
        );
    end

    assign ss = press[0];
    assign lr = press[1];

    state_t        st;
    logic [PW-1:0] presc;
    logic [CW-1:0] lap_q;
    logic          ovf_q;
    logic          running;
    logic          sec_tick;
    logic          at_max;
    logic          term;

    assign running  = (st == RUN) || (st == LAP);
    assign sec_tick = running && (presc == PRESC_TOP);
    assign at_max   = (bus.sec_count == CNT_TOP);
    assign term     = sec_tick && at_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= IDLE;
            presc <= '0;
            lap_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            // STOP keeps the prescaler phase so a resume finishes the partial second.
            case (st)
                IDLE:     presc <= '0;
                RUN, LAP: presc <= (presc == PRESC_TOP) ? '0 : presc + 1'b1;
                default:  presc <= presc;
            endcase

            // Terminal count outranks any button; ss outranks lr when both arrive together.
            if (term) begin
                st    <= STOP;
                ovf_q <= 1'b1;
            end else if (ss) begin
                case (st)
                    IDLE: begin
                        st    <= RUN;
                        presc <= '0;
                    end
                    RUN, LAP: st <= STOP;
                    STOP:     st <= RUN;
                endcase
            end else if (lr) begin
                case (st)
                    RUN: begin
                        st    <= LAP;
                        lap_q <= bus.sec_count;
                    end
                    LAP:  st <= RUN;
                    STOP: begin
                        st    <= IDLE;
                        ovf_q <= 1'b0;
                    end
                    default: st <= st;
                endcase
            end
        end
    end

    assign bus.cnt_inc    = sec_tick & ~at_max;
    assign bus.cnt_clr    = (st == IDLE);
    assign bus.disp_value = (st == LAP) ? lap_q : bus.sec_count;
    assign bus.state      = st;
    assign bus.running    = running;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic,
// compared each cycle against a cycle-level behavioural model of the stopwatch.
module tb_stopwatch_ctrl;
    localparam int DIV       = 4;
    localparam int CW        = 8;
    localparam int MAX_COUNT = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    stopwatch_ctrl_if #(.CW(CW)) bus ();

    stopwatch_ctrl #(.DIV(DIV), .CW(CW), .MAX_COUNT(MAX_COUNT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Seconds counter driven by the controller's strobes.
    logic [CW-1:0] cnt;
    always @(posedge clk or posedge reset) begin
        if (reset)            cnt <= '0;
        else if (bus.cnt_clr) cnt <= '0;
        else if (bus.cnt_inc) cnt <= cnt + 1'b1;
    end
    assign bus.sec_count = cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: 0=IDLE 1=RUN 2=LAP 3=STOP
    int       m_state, m_presc, m_lap, m_ovf, m_cnt;
    bit [2:0] hs, hl;
    int       ss_next[4] = '{1, 3, 3, 1};
    int       lr_next[4] = '{0, 2, 1, 0};

    function automatic void model_reset();
        m_state = 0; m_presc = 0; m_lap = 0; m_ovf = 0; m_cnt = 0;
        hs = '0; hl = '0;
    endfunction

    function automatic void model_step(input bit ss_raw, input bit lr_raw);
        bit p_ss, p_lr, run, sec, term;
        int n_state, n_presc, n_cnt;
        p_ss = hs[1] & ~hs[2];
        p_lr = hl[1] & ~hl[2];
        run  = (m_state == 1) || (m_state == 2);
        sec  = run && (m_presc == DIV - 1);
        term = sec && (m_cnt == MAX_COUNT);
        n_cnt   = (m_state == 0) ? 0 : ((sec && !term) ? m_cnt + 1 : m_cnt);
        n_presc = (m_state == 0) ? 0 : (run ? (m_presc + 1) % DIV : m_presc);
        n_state = m_state;
        if (term) begin
            n_state = 3;
            m_ovf   = 1;
        end else if (p_ss) begin
            n_state = ss_next[m_state];
        end else if (p_lr) begin
            n_state = lr_next[m_state];
            if (m_state == 1) m_lap = m_cnt;
        end
        if (n_state == 0) m_ovf = 0;
        m_state = n_state;
        m_presc = n_presc;
        m_cnt   = n_cnt;
        hs = {hs[1:0], ss_raw};
        hl = {hl[1:0], lr_raw};
    endfunction

    // Called at a falling edge: check this cycle, drive the next inputs, advance one cycle.
    task automatic tick(input bit ss, input bit lr);
        bit run;
        run = (m_state == 1) || (m_state == 2);
        chk("state",     bus.state,      m_state);
        chk("running",   bus.running,    run);
        chk("cnt_inc",   bus.cnt_inc,    run && m_presc == DIV - 1 && m_cnt != MAX_COUNT);
        chk("cnt_clr",   bus.cnt_clr,    m_state == 0);
        chk("ovf",       bus.ovf,        m_ovf);
        chk("disp",      bus.disp_value, (m_state == 2) ? m_lap : m_cnt);
        chk("sec_count", bus.sec_count,  m_cnt);
        bus.btn_ss = ss;
        bus.btn_lr = lr;
        model_step(ss, lr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_state",   bus.state,      0);
        chk("rst_running", bus.running,    0);
        chk("rst_cnt_inc", bus.cnt_inc,    0);
        chk("rst_cnt_clr", bus.cnt_clr,    1);
        chk("rst_ovf",     bus.ovf,        0);
        chk("rst_disp",    bus.disp_value, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_state(input int s, input int bound, input string tag);
        int n = 0;
        while (bus.state != s && n < bound) begin
            tick(0, 0);
            n++;
        end
        chk(tag, bus.state, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, inc_seen;
        bit cur_ss, cur_lr;
        bus.btn_ss = 1'b0;
        bus.btn_lr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_state",   bus.state,   0);
        chk("init_cnt_clr", bus.cnt_clr, 1);
        chk("init_cnt_inc", bus.cnt_inc, 0);
        chk("init_ovf",     bus.ovf,     0);
        reset = 1'b0;
        repeat (3) tick(0, 0);

        // Reset and start: latency, first strobe, strobe period.
        tick(1, 0);
        n = 1;
        while (bus.state != 1 && n < 10) begin tick(0, 0); n++; end
        chk("start_lat", n, 3);
        chk("clr_in_run", bus.cnt_clr, 0);
        n = 1;
        while (!bus.cnt_inc && n < 20) begin tick(0, 0); n++; end
        chk("first_inc", n, DIV);
        tick(0, 0);
        n = 1;
        while (!bus.cnt_inc && n < 20) begin tick(0, 0); n++; end
        chk("inc_period", n, DIV);

        // Lap hold at count 2.
        k = 0;
        while (!(m_cnt == 2 && m_presc == 0 && m_state == 1) && k < 50) begin tick(0, 0); k++; end
        tick(0, 1);
        repeat (8) tick(0, 0);
        chk("lap_state", bus.state, 2);
        chk("lap_disp",  bus.disp_value, 2);
        chk("lap_live",  bus.sec_count, 4);
        tick(0, 1);
        wait_state(1, 10, "lap_release");
        chk("live_disp", bus.disp_value, m_cnt);

        // Terminal count, then resume stays stuck.
        wait_state(3, 40, "term_state");
        chk("term_ovf", bus.ovf, 1);
        chk("term_cnt", bus.sec_count, MAX_COUNT);
        tick(1, 0);
        wait_state(1, 10, "term_resume");
        n = 0;
        while (bus.state == 1 && n < 20) begin tick(0, 0); n++; end
        chk("term_rerun", n, DIV);
        chk("term_ovf2",  bus.ovf, 1);
        chk("term_cnt2",  bus.sec_count, MAX_COUNT);

        // Clear from STOP.
        tick(0, 1);
        wait_state(0, 10, "clear_state");
        chk("clear_ovf", bus.ovf, 0);
        chk("clear_clr", bus.cnt_clr, 1);
        tick(0, 0);
        chk("clear_cnt", bus.sec_count, 0);

        // Pause with residual prescaler phase.
        tick(1, 0);
        wait_state(1, 10, "pause_run");
        k = 0;
        while (m_presc != DIV - 1 && k < 10) begin tick(0, 0); k++; end
        tick(1, 0);
        wait_state(3, 10, "pause_stop");
        inc_seen = 0;
        repeat (20) begin
            inc_seen += int'(bus.cnt_inc);
            tick(0, 0);
        end
        chk("pause_inc", inc_seen, 0);
        tick(1, 0);
        wait_state(1, 10, "pause_resume");
        n = 1;
        while (!bus.cnt_inc && n < 20) begin tick(0, 0); n++; end
        chk("resume_inc", n, 2);

        // Simultaneous presses in RUN: ss wins.
        tick(1, 1);
        wait_state(3, 10, "simul_stop");

        // Asynchronous reset mid-RUN with start held across deassertion.
        tick(1, 0);
        wait_state(1, 10, "pre_rst_run");
        repeat (2) tick(0, 0);
        tick(1, 0);
        do_reset();
        repeat (3) tick(1, 0);
        repeat (4) tick(0, 0);
        chk("held_rst_run", bus.state, 1);

        // Random button traffic with occasional resets.
        cur_ss = 1'b0;
        cur_lr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) cur_ss = ~cur_ss;
            if ($urandom_range(0, 5) == 0) cur_lr = ~cur_lr;
            tick(cur_ss, cur_lr);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
